// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter/rotator.
//   shift_op_e   : operation encoding carried on in_op (5..7 all mean PASS)
//   shift_clog2  : constant-function log2 helper used to size the amount port
//   shift_level  : one log-shifter level, shifting/rotating by 2^j when enabled
// shift_level works on a MAX_W-bit container with the live value right-aligned
// in the low `w` bits; callers zero-extend into it and truncate back out.
package shift_pkg;

  localparam int MAX_W = 1024;

  typedef enum logic [2:0] {
    OP_SLL  = 3'd0,
    OP_SRL  = 3'd1,
    OP_SRA  = 3'd2,
    OP_ROL  = 3'd3,
    OP_ROR  = 3'd4,
    OP_PASS = 3'd5
  } shift_op_e;

  function automatic int shift_clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] shift_level(
    input logic [MAX_W-1:0] data,
    input logic [2:0]       op,
    input logic             sign,
    input int               j,
    input logic             en,
    input int               w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] fill;
    logic [MAX_W-1:0] r;
    int               s;
    s    = 1 << j;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    // SRA fill is the operand's original sign, not the current MSB, so it
    // stays correct no matter which level runs first.
    fill = sign ? (mask & ~(mask >> s)) : '0;
    r    = data;
    if (en) begin
      case (op)
        OP_SLL:  r = (data << s) & mask;
        OP_SRL:  r = data >> s;
        OP_SRA:  r = (data >> s) | fill;
        OP_ROL:  r = ((data << s) | (data >> (w - s))) & mask;
        OP_ROR:  r = ((data >> s) | (data << (w - s))) & mask;
        default: r = data;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of shift_pipe: applies log levels LO..HI combinationally
// to the incoming operand, then registers data, amount, op and sign.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              operand from previous stage (or upstream) is valid
//   in_data/amt/op/sign   operand, full shift amount, op code, original sign
//   out_ready             next stage (or downstream) takes this stage's content
//   out_valid/data/...    registered stage content
// The stage loads whenever it is empty or its content is being taken.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int LO    = 0,
  parameter int HI    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic             in_sign,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [2:0]       out_op,
  output logic             out_sign
);

  logic [WIDTH-1:0] lvl_data_p0;
  logic [SHW-1:0]   amt_sh;
  logic             load;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SHW-1:0]   amt_p1;
  logic [2:0]       op_p1;
  logic             sign_p1;

  always_comb begin
    lvl_data_p0 = in_data;
    amt_sh      = '0;
    for (int j = LO; j <= HI; j++) begin
      amt_sh      = in_amt >> j;
      lvl_data_p0 = WIDTH'(shift_level(MAX_W'(lvl_data_p0), in_op, in_sign,
                                       j, amt_sh[0], WIDTH));
    end
  end

  assign load = !vld_p1 || out_ready;

  // ---- stage register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      amt_p1  <= '0;
      op_p1   <= '0;
      sign_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1 <= lvl_data_p0;
        amt_p1  <= in_amt;
        op_p1   <= in_op;
        sign_p1 <= in_sign;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_amt   = amt_p1;
  assign out_op    = op_p1;
  assign out_sign  = sign_p1;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined, parametrised barrel shifter/rotator with valid/ready handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake; in_ready only depends on stage valids
//                   and out_ready (no path from in_* to out_*)
//   in_data         operand (WIDTH bits)
//   in_amt          shift/rotate amount 0..WIDTH-1
//   in_op           0=SLL 1=SRL 2=SRA 3=ROL 4=ROR 5..7=PASS
//   out_valid/ready downstream handshake
//   out_data        result, STAGES register stages after acceptance
//   out_zero        out_data == 0, derived from the final stage register
// Log level j lives in stage floor(j*STAGES/SHW).
module shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  localparam int SHW    = shift_clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  // Index s is the input side of stage s; index STAGES is the pipe output.
  logic [STAGES:0]  vld_c;
  logic [STAGES:0]  rdy_c;
  logic [STAGES:0]  sign_c;
  logic [WIDTH-1:0] data_c [0:STAGES];
  logic [SHW-1:0]   amt_c  [0:STAGES];
  logic [2:0]       op_c   [0:STAGES];
  logic             unused_tail;

  assign vld_c[0]  = in_valid;
  assign data_c[0] = in_data;
  assign amt_c[0]  = in_amt;
  assign op_c[0]   = in_op;
  assign sign_c[0] = in_data[WIDTH-1];

  // Ready chain: a stage can take new content when it is empty or when the
  // stage after it is loading. Built only from registered valids and
  // out_ready, so it never loops back through itself.
  always_comb begin
    rdy_c         = '0;
    rdy_c[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy_c[s] = !vld_c[s+1] || rdy_c[s+1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = (s * SHW + STAGES - 1) / STAGES;
    localparam int HI = ((s + 1) * SHW + STAGES - 1) / STAGES - 1;

    shift_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_c[s]),
      .in_data   (data_c[s]),
      .in_amt    (amt_c[s]),
      .in_op     (op_c[s]),
      .in_sign   (sign_c[s]),
      .out_ready (rdy_c[s+1]),
      .out_valid (vld_c[s+1]),
      .out_data  (data_c[s+1]),
      .out_amt   (amt_c[s+1]),
      .out_op    (op_c[s+1]),
      .out_sign  (sign_c[s+1])
    );
  end

  // Amount, op and sign are spent once the last level has run.
  assign unused_tail = ^{amt_c[STAGES], op_c[STAGES], sign_c[STAGES]};

  assign in_ready  = rdy_c[0];
  assign out_valid = vld_c[STAGES];
  assign out_data  = data_c[STAGES];
  assign out_zero  = (data_c[STAGES] == '0);

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  // Sweep instances: g0 W8/S1, g1 W8/S3, g2 W64/S1, g3 W64/S6
  logic        sw_valid;
  logic [63:0] sw_data;
  logic [5:0]  sw_amt;
  logic [2:0]  sw_op;
  logic [63:0] sw_out  [4];
  logic        sw_vld  [4];
  logic        sw_zero [4];
  logic        sw_rdy  [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W  = (g < 2) ? 8 : 64;
    localparam int SH = $clog2(W);
    localparam int ST = (g % 2 == 0) ? 1 : SH;
    logic [W-1:0] dout;
    logic         vo;
    logic         zo;
    logic         ir;
    shift_pipe #(.WIDTH(W), .STAGES(ST)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (ir),
      .in_data   (sw_data[W-1:0]),
      .in_amt    (sw_amt[SH-1:0]),
      .in_op     (sw_op),
      .out_valid (vo),
      .out_ready (1'b1),
      .out_data  (dout),
      .out_zero  (zo)
    );
    assign sw_out[g]  = 64'(dout);
    assign sw_vld[g]  = vo;
    assign sw_zero[g] = zo;
    assign sw_rdy[g]  = ir;
  end

  function automatic int w_of(input int g);
    return (g < 2) ? 8 : 64;
  endfunction

  function automatic int st_of(input int g);
    if (g % 2 == 0) return 1;
    return (g < 2) ? 3 : 6;
  endfunction

  function automatic logic bit_at(input logic [63:0] d, input int k);
    logic [63:0] t;
    t = d >> k;
    return t[0];
  endfunction

  // Bit-by-bit reference: result bit i is picked straight from the operand.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                            input int op, input int w);
    logic [63:0] r;
    logic        b;
    int          a;
    r = '0;
    a = amt % w;
    for (int i = 0; i < w; i++) begin
      case (op)
        0:       b = (i >= a) ? bit_at(d, i - a) : 1'b0;
        1:       b = (i + a < w) ? bit_at(d, i + a) : 1'b0;
        2:       b = (i + a < w) ? bit_at(d, i + a) : bit_at(d, w - 1);
        3:       b = bit_at(d, (i - a + w) % w);
        4:       b = bit_at(d, (i + a) % w);
        default: b = bit_at(d, i);
      endcase
      r = r | (64'(b) << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic [2:0]  op;
    logic [31:0] exp;
    logic        zero;
  } vec_t;

  vec_t        tv [16];
  logic [31:0] bp_data [8];
  logic [31:0] bp_exp  [8];
  int          bp_amt  [8];
  int          bp_op   [8];
  logic [63:0] sv_data [512];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          sent;
    int          rcv;
    logic        acc;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        pat_bit;
    logic [31:0] bp_pat;

    tv[0]  = '{32'h0000_00FF, 5'd4,  3'd0, 32'h0000_0FF0, 1'b0};
    tv[1]  = '{32'hFF00_00FF, 5'd16, 3'd2, 32'hFFFF_FF00, 1'b0};
    tv[2]  = '{32'hFF00_00FF, 5'd16, 3'd1, 32'h0000_FF00, 1'b0};
    tv[3]  = '{32'h7000_0000, 5'd31, 3'd2, 32'h0000_0000, 1'b1};
    tv[4]  = '{32'h8000_0001, 5'd1,  3'd3, 32'h0000_0003, 1'b0};
    tv[5]  = '{32'h8000_0001, 5'd1,  3'd4, 32'hC000_0000, 1'b0};
    tv[6]  = '{32'h1234_5678, 5'd9,  3'd7, 32'h1234_5678, 1'b0};
    tv[7]  = '{32'h0000_0000, 5'd0,  3'd5, 32'h0000_0000, 1'b1};
    tv[8]  = '{32'h8000_0000, 5'd31, 3'd2, 32'hFFFF_FFFF, 1'b0};
    tv[9]  = '{32'h1234_5678, 5'd8,  3'd3, 32'h3456_7812, 1'b0};
    tv[10] = '{32'h1234_5678, 5'd24, 3'd4, 32'h3456_7812, 1'b0};
    tv[11] = '{32'h1234_5678, 5'd0,  3'd0, 32'h1234_5678, 1'b0};
    tv[12] = '{32'h8000_0000, 5'd31, 3'd1, 32'h0000_0001, 1'b0};
    tv[13] = '{32'h0000_0001, 5'd31, 3'd0, 32'h8000_0000, 1'b0};
    tv[14] = '{32'h8000_0000, 5'd4,  3'd2, 32'hF800_0000, 1'b0};
    tv[15] = '{32'h0000_000F, 5'd30, 3'd3, 32'hC000_0003, 1'b0};

    for (int i = 0; i < 8; i++) begin
      bp_data[i] = 32'h8123_4567 ^ (32'(i) * 32'h0101_1011);
      bp_amt[i]  = (i * 7 + 1) % 32;
      bp_op[i]   = i % 5;
      bp_exp[i]  = 32'(ref_shift(64'(bp_data[i]), bp_amt[i], bp_op[i], 32));
    end
    for (int k = 0; k < 512; k++) begin
      sv_data[k] = (k % 37 == 0) ? 64'd0 : {$urandom(), $urandom()};
    end
    bp_pat = 32'hB53C_96E1;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
    out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = '0; sw_amt = '0; sw_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_zero",  64'(out_zero),  64'd1);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;

    // Directed table: one operand at a time, latency checked each time
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = tv[i].data; in_amt = tv[i].amt; in_op = tv[i].op;
      #1;
      chk("tv_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tv_early_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("tv_out_valid", 64'(out_valid), 64'd1);
      chk("tv_out_data",  64'(out_data),  64'(tv[i].exp));
      chk("tv_out_zero",  64'(out_zero),  64'(tv[i].zero));
    end
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure stream
    sent = 0; rcv = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 200 && rcv < 8; c++) begin
      if (prev_stall) begin
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_data",  64'(out_data),  64'(prev_data));
      end
      pat_bit   = bit_at(64'(bp_pat), c % 32);
      out_ready = (c < 4) ? 1'b0 : pat_bit;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = bp_data[sent]; in_amt = 5'(bp_amt[sent]); in_op = 3'(bp_op[sent]);
      end
      #1;
      if (c == 2) begin
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_full_accepts",  64'(sent),     64'd2);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("bp_data", 64'(out_data), 64'(bp_exp[rcv]));
        rcv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(rcv), 64'd8);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with two operands in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'hAAAA_0000 + 32'(i); in_amt = 5'd1; in_op = 3'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_zero",  64'(out_zero),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_0003; in_amt = 5'd2; in_op = 3'd0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data",  64'(out_data),  64'h0000_000C);
    @(posedge clk); #1;

    // Width/stage sweep: all ops x all amounts, streamed back to back
    for (int c = 0; c < 512 + 6; c++) begin
      if (c < 512) begin
        sw_valid = 1'b1; sw_data = sv_data[c]; sw_amt = 6'(c % 64); sw_op = 3'(c / 64);
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      if (c < 512) begin
        for (int g = 0; g < 4; g++) chk("sw_in_ready", 64'(sw_rdy[g]), 64'd1);
      end
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        int          idx;
        logic [63:0] e;
        idx = c - (st_of(g) - 1);
        if (idx >= 0 && idx < 512) begin
          e = ref_shift(sv_data[idx], idx % 64, idx / 64, w_of(g));
          chk("sw_valid", 64'(sw_vld[g]),  64'd1);
          chk("sw_data",  sw_out[g],       e);
          chk("sw_zero",  64'(sw_zero[g]), 64'(e == 64'd0));
        end else if (idx < 0) begin
          chk("sw_early_valid", 64'(sw_vld[g]), 64'd0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
